param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
Parametrised successor to the 4-bit loadable up counter. Width and modulus are configurable. It counts up or down and supports synchronous load, a count enable, and an optional clock-enable prescaler. A parameter selects wrap or saturate at the boundaries, and the block provides terminal-count, boundary-event and sticky overflow status. It is used as a general timer/event counter wherever a plain 4-bit up counter is too limited.

Parameters:
WIDTH, 4, counter width in bits (2..16).
MAX_VAL, 2**WIDTH-1, top count value. Counting runs over 0..MAX_VAL; MAX_VAL must be at least 1.
SATURATE, 0, boundary mode. 0 = wrap modulo MAX_VAL+1; 1 = hold at the boundary.
PRESCALE, 1, number of enabled clock cycles per count step (1..256).

Ports:
clk  input  1  system clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; the prescaler advances only while en=1.
up_dn  input  1  direction: 1 = up, 0 = down; sampled at each step.
load  input  1  synchronous load of d_in.
d_in  input  WIDTH  load value.
clr_flags  input  1  synchronous clear of ovf_sticky.
c_out  output  WIDTH  registered count value.
tc  output  1  terminal count, combinational: (up_dn=1 and c_out==MAX_VAL) or (up_dn=0 and c_out==0).
bnd_pulse  output  1  registered one-cycle pulse on each boundary event.
ovf_sticky  output  1  registered flag, set by any boundary event.

Behaviour:
- Reset (asynchronous, rst=1):
  - c_out=0, bnd_pulse=0, ovf_sticky=0, prescaler count=0, all immediately.
  - Reset asserted mid-count or mid-load aborts the operation.
  - After rst deasserts, the first count step needs a full PRESCALE enabled cycles.
- Priority at each clock edge: rst > load > count step > hold.
- Load (load=1):
  - c_out <= min(d_in, MAX_VAL); values above MAX_VAL clamp to MAX_VAL.
  - Prescaler count <= 0; bnd_pulse <= 0.
  - Load takes effect regardless of en and suppresses any step due in that cycle.
- Prescaler:
  - tick = en and (pre_cnt == PRESCALE-1).
  - When en=1: pre_cnt increments, and wraps to 0 on tick.
  - When en=0: pre_cnt holds.
  - With PRESCALE=1, tick = en.
- Count step, on tick with load=0:
  - Up, c_out<MAX_VAL: c_out+1.
  - Up, c_out==MAX_VAL: boundary event. Next value is 0 if SATURATE=0; holds MAX_VAL if SATURATE=1.
  - Down, c_out>0: c_out-1.
  - Down, c_out==0: boundary event. Next value is MAX_VAL if SATURATE=0; holds 0 if SATURATE=1.
  - Latency: c_out changes on the same edge that samples tick (one clock from inputs to output).
- Boundary event:
  - bnd_pulse=1 for exactly the cycle after the event edge; otherwise 0.
  - Back-to-back events, such as saturate with en held at PRESCALE=1, hold bnd_pulse high on consecutive cycles.
  - ovf_sticky <= 1 on the event.
- clr_flags:
  - Clears ovf_sticky on the next edge.
  - If clr_flags and a boundary event occur in the same cycle, the set wins (ovf_sticky=1).
- Direction change:
  - up_dn may change on any cycle; there is no effect on pre_cnt.
  - tc follows the new direction immediately (combinational).
- c_out never exceeds MAX_VAL, and all arithmetic is WIDTH bits.
- No X propagation: outputs are defined from reset onward.

Test Plan:
1. Reset and up-count: WIDTH=4, MAX_VAL=9, SATURATE=0, PRESCALE=1; assert rst; en=1, up_dn=1 -> c_out runs 0,1..9,0. On the 9->0 edge, bnd_pulse is 1 for one cycle and ovf_sticky=1. tc=1 while c_out=9.
2. Load with clamp: same config; apply load with d_in=6 -> c_out=6 on the next edge, with no step that cycle. Then load d_in=14 -> c_out=9. Load with en=0 -> still loads.
3. Down and saturate: SATURATE=1, MAX_VAL=9; load 2, up_dn=0 -> c_out 2,1,0,0,0. bnd_pulse is high on each hold-at-0 step; ovf_sticky=1. Pulse clr_flags while still at 0 with en=1 -> ovf_sticky stays 1 (set wins). Then set en=0 and pulse clr_flags -> ovf_sticky=0.
4. Prescaler: PRESCALE=3, en=1 -> c_out increments every 3rd clock. Toggling en low for 2 cycles stretches the interval by 2. A load mid-interval restarts the 3-cycle count.
5. Async reset mid-operation: while counting at c_out=5, assert rst between clock edges -> c_out=0, bnd_pulse=0 and ovf_sticky=0 before the next edge. After release, counting resumes from 0.
6. Direction flip at the boundary: c_out=9, up_dn=1 (tc=1); switch up_dn=0 -> tc=0 immediately, and the next step gives c_out=8 with no boundary event.

Source files
------------

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Brief    : Up/down counter with load, prescaled enable, wrap or saturate
//            boundary mode, and terminal-count / boundary / overflow status.
// Revision : 1.0
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] c_out,
    output logic             tc,
    output logic             bnd_pulse,
    output logic             ovf_sticky
);

    localparam int             c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] c_MAX_VAL = WIDTH'(MAX_VAL);
    localparam logic [c_PW-1:0]  c_PRE_TOP = c_PW'(PRESCALE - 1);

    logic [WIDTH-1:0] r_count;
    logic [c_PW-1:0]  r_pre;
    logic             r_bnd_pulse;
    logic             r_ovf;

    logic             w_tick;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_bnd;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_val;

    assign w_tick     = en && (r_pre == c_PRE_TOP);
    assign w_at_top   = (r_count == c_MAX_VAL);
    assign w_at_bot   = (r_count == '0);
    assign w_bnd      = w_tick && !load && (up_dn ? w_at_top : w_at_bot);
    assign w_load_val = (d_in > c_MAX_VAL) ? c_MAX_VAL : d_in;

    // At a boundary, wrap to the opposite end or hold, depending on mode.
    always_comb begin
        w_step = r_count;
        if (up_dn) begin
            if (!w_at_top)
                w_step = r_count + WIDTH'(1);
            else if (SATURATE == 0)
                w_step = '0;
        end else begin
            if (!w_at_bot)
                w_step = r_count - WIDTH'(1);
            else if (SATURATE == 0)
                w_step = c_MAX_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_pre       <= '0;
            r_bnd_pulse <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (load) begin
                r_count     <= w_load_val;
                r_pre       <= '0;
                r_bnd_pulse <= 1'b0;
            end else begin
                if (en)
                    r_pre <= w_tick ? '0 : r_pre + c_PW'(1);
                if (w_tick)
                    r_count <= w_step;
                r_bnd_pulse <= w_bnd;
            end
            // A boundary event in the same cycle as a clear keeps the flag set.
            if (w_bnd)
                r_ovf <= 1'b1;
            else if (clr_flags)
                r_ovf <= 1'b0;
        end
    end

    assign c_out      = r_count;
    assign tc         = up_dn ? w_at_top : w_at_bot;
    assign bnd_pulse  = r_bnd_pulse;
    assign ovf_sticky = r_ovf;

endmodule
`default_nettype wire
